// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC's sync reset and relative-branch inputs,
// registers ROM words into the instruction register, squashes wrong-path slots, detects halt.
module fetch_ctrl #(
    parameter int W  = 8,
    parameter int I  = 9,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  pc,
    input  logic [I-1:0]  instr_in,
    input  logic          zero,
    output logic          pc_reset,
    output logic          branch_rel,
    output logic [W-1:0]  target,
    output logic [I-1:0]  instr,
    output logic          instr_valid,
    output logic          done,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [I-1:0]  HALT_WORD = '1;
    localparam logic [CW-1:0] COUNT_MAX = '1;

    state_t        state, state_next;
    logic [I-1:0]  ir, ir_next;
    logic          valid_next;
    logic          done_next;
    logic [CW-1:0] count_next;

    logic          ir_is_halt;
    logic          ir_is_branch;
    logic [5:0]    offset;

    // The PC value is observed only through the ROM word it addresses.
    logic unused_pc;
    assign unused_pc = ^pc;

    assign ir_is_halt   = (ir == HALT_WORD);
    assign ir_is_branch = (ir[I-1 -: 3] == 3'b111) && !ir_is_halt;
    assign offset       = ir[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ir          <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_next;
            ir          <= ir_next;
            instr_valid <= valid_next;
            done        <= done_next;
            cycle_count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        ir_next    = ir;
        valid_next = instr_valid;
        done_next  = done;
        count_next = cycle_count;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_next = FETCH;
                    ir_next    = '0;
                    valid_next = 1'b0;
                    done_next  = 1'b0;
                    count_next = '0;
                end
            end
            FETCH: begin
                if (cycle_count != COUNT_MAX) begin
                    count_next = cycle_count + CW'(1);
                end
                if (instr_valid && ir_is_halt) begin
                    state_next = HALT;
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                end else if (instr_valid && ir_is_branch && zero) begin
                    // The word fetched at branch+1 is wrong-path; replace it with a bubble.
                    ir_next    = '0;
                    valid_next = 1'b0;
                end else begin
                    ir_next    = instr_in;
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC already points one past the branch, hence offset+1.
    assign pc_reset   = (state != FETCH);
    assign branch_rel = (state == FETCH) && instr_valid && ir_is_branch;
    assign target     = branch_rel ? (W'(offset) + W'(1)) : '0;
    assign instr      = ir;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller at the consuming end of the program counter. It drives the PC's sync reset and relative-branch inputs and samples the instruction ROM word addressed by the PC. It registers that word into an instruction register for decode and squashes the wrong-path slot after a taken branch. It also detects halt and runs a saturating cycle counter for program-length measurement.

## Interface

- W, 8: PC / Target width
- I, 9: instruction width
- CW, 16: cycle counter width

- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; forces IDLE immediately
- Start  in  1  single-cycle run request
- PC  in  W  current program counter
- InstrIn  in  I  ROM word at PC (combinational read)
- Zero  in  1  datapath zero flag (same signal the PC gates BranchRel with)
- PcReset  out  1  synchronous reset to PC
- BranchRel  out  1  relative-branch request to PC
- Target  out  W  backward offset; PC loads PC − Target when BranchRel & Zero
- Instr  out  I  instruction register to decode
- InstrValid  out  1  Instr is a real instruction this cycle
- Done  out  1  program halted
- CycleCount  out  CW  cycles spent in FETCH for the last/current run

## Operation

- Encodings (I=9):
  - halt = 9'h1FF
  - branch-back = InstrIn[8:6]==3'b111 and not halt; offset = [5:0], zero-extended to W
  - everything else is opaque and passed through
- States: IDLE, FETCH, HALT. Reset → IDLE.
- IDLE/HALT: PcReset=1, which holds PC at 0. On Start → FETCH and clear CycleCount to 0. Start in FETCH is ignored.
- FETCH: PcReset=0. Each edge, the first matching rule applies:
  - IR valid and IR==halt → state HALT, InstrValid←0, Done←1
  - IR valid, IR is branch, Zero=1 (taken) → IR←0, InstrValid←0 (squash the PC+1 slot)
  - otherwise → IR←InstrIn, InstrValid←1
- BranchRel = (state==FETCH) & InstrValid & IR is branch. It is decoded from registers only.
- Target = BranchRel ? offset+1 : 0, computed mod 2^W. The +1 compensates for the PC already pointing at the branch address+1. Destination = branch address − offset; offset 0 branches to itself.
- A squashed slot never decodes as a branch or halt, so back-to-back branches need no extra handling.
- Done: set entering HALT, cleared on Start.
- CycleCount: increments at every edge taken in FETCH, including the exiting edge. It saturates at all-ones and holds in IDLE/HALT.

## Timing

- Reset values (asynchronous):
  - state=IDLE, IR=0, InstrValid=0, Done=0, CycleCount=0
  - PcReset=1, BranchRel=0, Target=0
- Start sampled at edge 0:
  - PC=0 during cycle 1, with InstrValid=0
  - first InstrValid=1 (instr @0) in cycle 2
- Fetch latency: ROM word at PC appears on Instr one cycle later.
- Taken branch: a branch in IR at cycle n with Zero=1 gives one bubble at n+1, and the destination instruction is valid at n+2.
- Not-taken branch: no bubble.
- Halt: halt valid on Instr at cycle n; Done=1 and InstrValid=0 from n+1. PC is forced to 0 from n+2.
- Reset asserted mid-run: all outputs return to reset values without waiting for Clk, and any pending squash or branch is discarded.

## Test plan

- Reset with Clk stopped → PcReset=1, InstrValid=0, Done=0, BranchRel=0, Target=0, CycleCount=0. Idle 10 cycles → PC stays 0.
- ROM[0..3]=001,002,003,1FF; Start → Instr 001/002/003/1FF valid on cycles 2–5 with no gaps. Done=1 from cycle 6; CycleCount=5.
- ROM[0..3]=001,003,1C1,0AA; Zero=1 while 1C1 is in IR:
  - BranchRel=1, Target=2, PC 3→1
  - next cycle InstrValid=0 (0AA never issued), then Instr=003 valid
- Same program with Zero=0 → BranchRel=1 but PC 3→4. 0AA is issued the next cycle with no bubble.
- Offset 0 (ROM[2]=1C0, Zero=1) → Target=1, PC returns to 2. The branch re-issues every 2 cycles with a bubble between. CycleCount saturates at 16'hFFFF after a long run.
- Reset asserted asynchronously mid-FETCH → outputs at reset values before the next edge. Start during FETCH is ignored; Start in HALT restarts from PC 0 with CycleCount cleared.
